// File: rtl/alu_pkg.sv
// Shared ALU definitions for the issue controller: ALU control codes,
// MIPS R-type funct values and the funct decode helper.
package alu_pkg;

    // ALU control codes driven on alu_con
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MULT = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SUBU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;

    // MIPS R-type funct field values
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [3:0] code;    // ALU control code
        logic       legal;   // funct is supported
        logic       ovf_op;  // signed add/sub: overflow is reported
    } alu_dec_t;

    // Map funct to {code, legal, ovf_op}; unsupported funct decodes to AND, illegal.
    function automatic alu_dec_t alu_decode(input logic [5:0] funct);
        alu_dec_t d;
        d = '{code: ALU_AND, legal: 1'b1, ovf_op: 1'b0};
        case (funct)
            FN_AND:  d.code = ALU_AND;
            FN_OR:   d.code = ALU_OR;
            FN_ADD:  begin d.code = ALU_ADD; d.ovf_op = 1'b1; end
            FN_ADDU: d.code = ALU_ADD;
            FN_MULT: d.code = ALU_MULT;
            FN_NOR:  d.code = ALU_NOR;
            FN_SUB:  begin d.code = ALU_SUB; d.ovf_op = 1'b1; end
            FN_SLT:  d.code = ALU_SLT;
            FN_SLL:  d.code = ALU_SLL;
            FN_SUBU: d.code = ALU_SUBU;
            FN_XOR:  d.code = ALU_XOR;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response signals of the ALU issue controller.
// master: the issue controller; slave: decode/ALU/writeback environment.
interface alu_issue_ctrl_if #(parameter int TAG_W = 5) ();

    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_funct;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic [3:0]       alu_con;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;
    logic             alu_overflow;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_ovf;
    logic             rsp_illegal;
    logic             rsp_trap;

    modport master (
        input  req_valid, req_funct, req_a, req_b, req_tag,
        output req_ready,
        output alu_con, alu_a, alu_b,
        input  alu_result, alu_overflow,
        output rsp_valid, rsp_result, rsp_tag, rsp_ovf, rsp_illegal, rsp_trap,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_funct, req_a, req_b, req_tag,
        input  req_ready,
        input  alu_con, alu_a, alu_b,
        output alu_result, alu_overflow,
        input  rsp_valid, rsp_result, rsp_tag, rsp_ovf, rsp_illegal, rsp_trap,
        output rsp_ready
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO for the ALU issue controller.
// DEPTH must be a power of two (pointers wrap naturally); caller gates push/pop.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state pointers and occupancy; push+pop together leaves count unchanged
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so all update together at the edge.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count alone say which entries are live.
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: queues R-type requests, decodes funct to the ALU
// control code, drives the ALU from the queue head and registers the response.
// Optional feature: define ALU_OVF_TRAP_EN to trap on signed overflow
// (rsp_trap=1, rsp_result forced to 0); otherwise rsp_trap stays 0.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [5:0]       funct;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct packed {
        logic             valid;
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             illegal;
        logic             trap;
    } rsp_t;

    req_t             wr_ent, head;
    logic             full, empty, push, pop;
    logic [CNT_W-1:0] count;
    alu_dec_t         dec;
    rsp_t             rsp_q, rsp_d;

    assign wr_ent = '{funct: bus.req_funct, a: bus.req_a, b: bus.req_b, tag: bus.req_tag};
    assign push   = bus.req_valid && !full;
    assign empty  = (count == '0);

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_t)),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_ent),
        .rd_data (head),
        .full    (full),
        .count   (count)
    );

    // Decode the head entry, drive the ALU and compute the next response
    always_comb begin
        dec         = alu_decode(head.funct);
        bus.alu_con = empty ? ALU_AND : dec.code;
        bus.alu_a   = empty ? 32'd0 : head.a;
        bus.alu_b   = empty ? 32'd0 : head.b;
        pop         = !empty && (!rsp_q.valid || bus.rsp_ready);

        rsp_d = rsp_q;
        if (pop) begin
            rsp_d.valid = 1'b1;
            rsp_d.tag   = head.tag;
            if (!dec.legal) begin
                rsp_d.result  = 32'd0;
                rsp_d.ovf     = 1'b0;
                rsp_d.illegal = 1'b1;
                rsp_d.trap    = 1'b0;
            end else begin
                rsp_d.ovf     = bus.alu_overflow && dec.ovf_op;
                rsp_d.illegal = 1'b0;
`ifdef ALU_OVF_TRAP_EN
                rsp_d.trap    = rsp_d.ovf;
                rsp_d.result  = rsp_d.ovf ? 32'd0 : bus.alu_result;
`else
                rsp_d.trap    = 1'b0;
                rsp_d.result  = bus.alu_result;
`endif
            end
        end else if (bus.rsp_ready) begin
            rsp_d.valid = 1'b0;
        end
    end

    // Response register: held while valid and not taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_q <= '0;
        else        rsp_q <= rsp_d;
    end

    assign bus.req_ready   = !full;
    assign bus.rsp_valid   = rsp_q.valid;
    assign bus.rsp_result  = rsp_q.result;
    assign bus.rsp_tag     = rsp_q.tag;
    assign bus.rsp_ovf     = rsp_q.ovf;
    assign bus.rsp_illegal = rsp_q.illegal;
    assign bus.rsp_trap    = rsp_q.trap;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the alu_* signals.
// Expected values track ALU_OVF_TRAP_EN when it is defined.
module tb_alu_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
`ifdef ALU_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [5:0]       f;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] t;
        logic [31:0]      res;
        logic             ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    vec_t fill_v [5];
    vec_t strm_v [5];

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    alu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU: add/sub codes raise the signed overflow flag
    logic [31:0] alu_r;
    logic        alu_v;
    always_comb begin
        alu_r = 32'd0;
        alu_v = 1'b0;
        case (bus.alu_con)
            4'b0000: alu_r = bus.alu_a & bus.alu_b;
            4'b0001: alu_r = bus.alu_a | bus.alu_b;
            4'b0010: begin
                alu_r = bus.alu_a + bus.alu_b;
                alu_v = (bus.alu_a[31] == bus.alu_b[31]) && (alu_r[31] != bus.alu_a[31]);
            end
            4'b0011: alu_r = bus.alu_a * bus.alu_b;
            4'b0100: alu_r = ~(bus.alu_a | bus.alu_b);
            4'b0110: begin
                alu_r = bus.alu_a - bus.alu_b;
                alu_v = (bus.alu_a[31] != bus.alu_b[31]) && (alu_r[31] != bus.alu_a[31]);
            end
            4'b0111: alu_r = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            4'b1000: alu_r = bus.alu_a << bus.alu_b[4:0];
            4'b1001: alu_r = bus.alu_a - bus.alu_b;
            4'b1010: alu_r = bus.alu_a ^ bus.alu_b;
            default: alu_r = 32'd0;
        endcase
        bus.alu_result   = alu_r;
        bus.alu_overflow = alu_v;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] t, input logic [31:0] res, input logic ovf);
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.t = t; v.res = res; v.ovf = ovf;
        return v;
    endfunction

    // Drive one request starting at a falling edge; returns at the falling edge after acceptance
    task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_funct = f;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = t;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Compare the currently held response against a vector
    task automatic check_rsp(input string name, input vec_t v, input logic illegal);
        logic [31:0] exp_res;
        logic        exp_trap;
        exp_trap = TRAP && v.ovf;
        exp_res  = exp_trap ? 32'd0 : v.res;
        check({name, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({name, "_result"}, bus.rsp_result, exp_res);
        check({name, "_tag"}, {27'd0, bus.rsp_tag}, {27'd0, v.t});
        check({name, "_flags"}, {29'd0, bus.rsp_ovf, bus.rsp_illegal, bus.rsp_trap},
              {29'd0, v.ovf, illegal, exp_trap});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        fill_v[0] = mk(6'h24, 32'hF0F0F0F0, 32'h0FF0FF00, 5'd10, 32'h00F0F000, 1'b0);
        fill_v[1] = mk(6'h25, 32'h12340000, 32'h00005678, 5'd11, 32'h12345678, 1'b0);
        fill_v[2] = mk(6'h26, 32'hFFFF0000, 32'h0F0F0F0F, 5'd12, 32'hF0F00F0F, 1'b0);
        fill_v[3] = mk(6'h2A, 32'hFFFFFFFF, 32'h00000001, 5'd13, 32'h00000001, 1'b0);
        fill_v[4] = mk(6'h27, 32'h00000000, 32'h00000000, 5'd14, 32'hFFFFFFFF, 1'b0);
        strm_v[0] = mk(6'h00, 32'h00000001, 32'h00000004, 5'd20, 32'h00000010, 1'b0);
        strm_v[1] = mk(6'h23, 32'h00000000, 32'h00000001, 5'd21, 32'hFFFFFFFF, 1'b0);
        strm_v[2] = mk(6'h18, 32'h00000003, 32'h00000005, 5'd22, 32'h0000000F, 1'b0);
        strm_v[3] = mk(6'h22, 32'h80000000, 32'h00000001, 5'd23, 32'h7FFFFFFF, 1'b1);
        strm_v[4] = mk(6'h20, 32'h00000002, 32'h00000003, 5'd24, 32'h00000005, 1'b0);

        bus.req_valid = 1'b0;
        bus.req_funct = 6'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_rsp_tag", {27'd0, bus.rsp_tag}, 32'd0);
        check("rst_alu_con", {28'd0, bus.alu_con}, 32'd0);

        // Signed add overflow, latency N+2
        send(6'h20, 32'h7FFFFFFF, 32'h00000001, 5'd3);
        check("add_lat_n1", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check_rsp("add_ovf", mk(6'h20, 32'h7FFFFFFF, 32'h1, 5'd3, 32'h80000000, 1'b1), 1'b0);
        @(negedge clk);
        check("add_drained", {31'd0, bus.rsp_valid}, 32'd0);

        // addu never flags overflow
        send(6'h21, 32'h7FFFFFFF, 32'h00000001, 5'd4);
        @(negedge clk);
        check_rsp("addu", mk(6'h21, 32'h7FFFFFFF, 32'h1, 5'd4, 32'h80000000, 1'b0), 1'b0);
        @(negedge clk);

        // Illegal funct followed by sub, in order, response held while stalled
        bus.rsp_ready = 1'b0;
        send(6'h3F, 32'h00000001, 32'h00000002, 5'd7);
        send(6'h22, 32'h00000005, 32'h00000007, 5'd8);
        check_rsp("illegal", mk(6'h3F, 32'h1, 32'h2, 5'd7, 32'h0, 1'b0), 1'b1);
        @(negedge clk);
        check("illegal_hold_tag", {27'd0, bus.rsp_tag}, 32'd7);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_rsp("sub_after_ill", mk(6'h22, 32'h5, 32'h7, 5'd8, 32'hFFFFFFFE, 1'b0), 1'b0);
        @(negedge clk);
        check("ill_drained", {31'd0, bus.rsp_valid}, 32'd0);

        // Fill output register plus FIFO, then drain one per cycle
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(fill_v[i].f, fill_v[i].a, fill_v[i].b, fill_v[i].t);
        check("full_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("full_head_con", {28'd0, bus.alu_con}, 32'h1);
        check("full_hold_result", bus.rsp_result, 32'h00F0F000);
        bus.rsp_ready = 1'b1;
        check("full_no_bypass", {31'd0, bus.req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_rsp($sformatf("fill%0d", i), fill_v[i], 1'b0);
            if (i == 1) check("full_slot_freed", {31'd0, bus.req_ready}, 32'd1);
            @(negedge clk);
        end
        check("fill_drained", {31'd0, bus.rsp_valid}, 32'd0);

        // Streaming, one request and one response per cycle
        for (int k = 0; k < 7; k++) begin
            if (k >= 2) check_rsp($sformatf("strm%0d", k - 2), strm_v[k - 2], 1'b0);
            if (k < 5) begin
                bus.req_valid = 1'b1;
                bus.req_funct = strm_v[k].f;
                bus.req_a     = strm_v[k].a;
                bus.req_b     = strm_v[k].b;
                bus.req_tag   = strm_v[k].t;
                check($sformatf("strm_ready%0d", k), {31'd0, bus.req_ready}, 32'd1);
            end else begin
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("strm_drained", {31'd0, bus.rsp_valid}, 32'd0);

        // Reset with requests queued discards everything
        bus.rsp_ready = 1'b0;
        send(6'h24, 32'h1, 32'h1, 5'd1);
        send(6'h25, 32'h2, 32'h2, 5'd2);
        send(6'h26, 32'h3, 32'h3, 5'd5);
        check("pre_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst2_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("no_stale%0d", i), {31'd0, bus.rsp_valid}, 32'd0);
        end
        send(6'h24, 32'h000000FF, 32'h0000000F, 5'd9);
        @(negedge clk);
        check_rsp("post_rst", mk(6'h24, 32'hFF, 32'hF, 5'd9, 32'h0000000F, 1'b0), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
